tile_mem_arbiter: RTL

Shares the single-port, synchronous-read tile memory between the display path and two game-logic writers. The display path comes from the VGA sync counters as tile coordinates plus pixel tick; the writers are player/flag update logic. Display reads have absolute priority, and writes are round-robin arbitrated. Optionally, writes are confined to vertical blanking so a frame never shows a half-updated board.

---
 rtl/tile_pkg.sv | 18 +
 rtl/tile_mem_arbiter_if.sv | 47 ++++
 rtl/rr_arb2.sv | 42 ++++
 rtl/tile_mem_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile memory arbiter slice.
// Slot encoding, address width and the {y,x} address packing used by display and writers.
package tile_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RD   = 2'd1,
    SLOT_WR   = 2'd2
  } slot_t;

  localparam int unsigned TILE_ADDR_W    = 8;
  localparam int unsigned DATA_W_DEFAULT = 4;

  function automatic logic [TILE_ADDR_W-1:0] tile_addr(input logic [3:0] y, input logic [3:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/tile_mem_arbiter_if.sv
// Bundle of display, writer and RAM signals around the tile memory arbiter.
// slave = arbiter view, master = environment (sync counters, writers, RAM) view.
interface tile_mem_arbiter_if
  import tile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic                   disp_tick;
  logic                   video_on;
  logic                   vblank;
  logic [3:0]             disp_x;
  logic [3:0]             disp_y;
  logic [DATA_W-1:0]      disp_data;
  logic                   disp_valid;

  logic [1:0]             wreq;
  logic [TILE_ADDR_W-1:0] waddr0;
  logic [TILE_ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0]      wdata0;
  logic [DATA_W-1:0]      wdata1;
  logic [1:0]             wgnt;

  logic [TILE_ADDR_W-1:0] mem_addr;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  disp_tick, video_on, vblank, disp_x, disp_y,
    output disp_data, disp_valid,
    input  wreq, waddr0, waddr1, wdata0, wdata1,
    output wgnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_tick, video_on, vblank, disp_x, disp_y,
    input  disp_data, disp_valid,
    output wreq, waddr0, waddr1, wdata0, wdata1,
    input  wgnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, rr_last updated only when a grant is issued.
// rr_last resets to 1 so writer 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt[0]) begin
      rr_last_d = 1'b0;
    end else if (gnt[1]) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Single-port tile RAM arbiter: display reads take absolute priority, two writers share the
// remaining slots round-robin, optionally only during vertical blanking.
module tile_mem_arbiter
  import tile_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter bit          LOCK_VBLANK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  tile_mem_arbiter_if.slave  bus
);

  logic                   rd_req;
  logic                   wr_window;
  logic [1:0]             elig;
  logic [1:0]             gnt;
  slot_t                  slot_q, slot_d;
  logic [1:0]             wgnt_q;
  logic [1:0]             rd_pipe_q;
  logic [TILE_ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [DATA_W-1:0]      disp_data_q;
  logic                   disp_valid_q;

  assign rd_req    = bus.disp_tick & bus.video_on;
  assign wr_window = !LOCK_VBLANK || bus.vblank;
  // A writer with a grant showing this cycle is still updating its request, so mask it.
  assign elig      = bus.wreq & ~wgnt_q & {2{wr_window}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .en    (~rd_req),
    .gnt   (gnt)
  );

  always_comb begin
    slot_d = SLOT_IDLE;
    if (rd_req) begin
      slot_d = SLOT_RD;
    end else if (|gnt) begin
      slot_d = SLOT_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= SLOT_IDLE;
      wgnt_q       <= 2'b00;
      rd_pipe_q    <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      wgnt_q       <= gnt;
      rd_pipe_q    <= {rd_pipe_q[0], slot_d == SLOT_RD};
      disp_valid_q <= rd_pipe_q[1];
      if (rd_pipe_q[1]) begin
        disp_data_q <= bus.mem_rdata;
      end
      unique case (slot_d)
        SLOT_RD: mem_addr_q <= tile_addr(bus.disp_y, bus.disp_x);
        SLOT_WR: begin
          mem_addr_q  <= gnt[0] ? bus.waddr0 : bus.waddr1;
          mem_wdata_q <= gnt[0] ? bus.wdata0 : bus.wdata1;
        end
        default: ;
      endcase
    end
  end

  assign bus.wgnt       = wgnt_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = (slot_q == SLOT_WR);
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;

endmodule
